// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU status / EX-MEM capture block.
package alu_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int RADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_Z  = 3'b001,
    COND_NZ = 3'b010,
    COND_C  = 3'b011,
    COND_NC = 3'b100,
    COND_HI = 3'b101,
    COND_LS = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  typedef struct packed {
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_status_unit_if.sv
// EX-side inputs and EX/MEM-side outputs of the ALU status unit.
// in_valid/out_valid are plain qualifiers with no ready; the only backpressure is stall.
interface alu_status_unit_if #(
  parameter int WIDTH   = alu_pkg::WIDTH_DEF,
  parameter int RADDR_W = alu_pkg::RADDR_W_DEF
);

  logic               stall;
  logic               flush;
  logic               in_valid;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic               alu_carry;
  logic               upd_z;
  logic               upd_c;
  logic               wb_en_in;
  logic [RADDR_W-1:0] wb_reg_in;
  logic               is_branch;
  logic [2:0]         cond;
  logic [WIDTH-1:0]   target_in;
  logic               flag_save;
  logic               flag_restore;

  logic               carry_to_alu;
  logic               z_flag;
  logic               c_flag;
  logic               out_valid;
  logic [WIDTH-1:0]   out_result;
  logic               out_wb_en;
  logic [RADDR_W-1:0] out_wb_reg;
  logic               branch_taken;
  logic [WIDTH-1:0]   branch_target;

  modport master (
    output stall, flush, in_valid, alu_result, alu_zero, alu_carry, upd_z, upd_c,
           wb_en_in, wb_reg_in, is_branch, cond, target_in, flag_save, flag_restore,
    input  carry_to_alu, z_flag, c_flag, out_valid, out_result, out_wb_en,
           out_wb_reg, branch_taken, branch_target
  );

  modport slave (
    input  stall, flush, in_valid, alu_result, alu_zero, alu_carry, upd_z, upd_c,
           wb_en_in, wb_reg_in, is_branch, cond, target_in, flag_save, flag_restore,
    output carry_to_alu, z_flag, c_flag, out_valid, out_result, out_wb_en,
           out_wb_reg, branch_taken, branch_target
  );

endinterface

// File: rtl/alu_status_unit_cond_eval.sv
// Combinational branch-condition evaluation against the committed Z/C flags.
module cond_eval
  import alu_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags.z;
      COND_NZ: taken = !flags.z;
      COND_C:  taken = flags.c;
      COND_NC: taken = !flags.c;
      COND_HI: taken = flags.c && !flags.z;
      COND_LS: taken = !flags.c || flags.z;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_unit.sv
// Z/C flag register with one-deep shadow, carry feedback to the ALU,
// branch resolution and the EX/MEM pipeline register.
module alu_status_unit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_status_unit_if.slave   bus
);

  flags_t flags_q;
  flags_t shadow_q;
  logic   advance;
  logic   cond_true;

  assign advance = !bus.stall && !bus.flush && bus.in_valid;

  cond_eval u_cond_eval (
    .cond  (cond_e'(bus.cond)),
    .flags (flags_q),
    .taken (cond_true)
  );

  // Flags commit at the end of EX, so the carry fed back needs no bypass.
  assign bus.carry_to_alu = flags_q.c;
  assign bus.z_flag       = flags_q.z;
  assign bus.c_flag       = flags_q.c;

  // Restore beats the ALU update; save samples pre-update flags, giving a swap when both fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      shadow_q <= '0;
    end else if (!bus.stall) begin
      if (bus.flag_restore) begin
        flags_q <= shadow_q;
      end else if (advance) begin
        if (bus.upd_z) flags_q.z <= bus.alu_zero;
        if (bus.upd_c) flags_q.c <= bus.alu_carry;
      end
      if (bus.flag_save) shadow_q <= flags_q;
    end
  end

  // flush takes priority over stall; it only clears the control fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_result    <= '0;
      bus.out_wb_en     <= 1'b0;
      bus.out_wb_reg    <= '0;
      bus.branch_taken  <= 1'b0;
      bus.branch_target <= '0;
    end else if (bus.flush) begin
      bus.out_valid    <= 1'b0;
      bus.out_wb_en    <= 1'b0;
      bus.branch_taken <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid     <= bus.in_valid;
      bus.out_result    <= bus.alu_result;
      bus.out_wb_en     <= bus.wb_en_in && bus.in_valid;
      bus.out_wb_reg    <= bus.wb_reg_in;
      bus.branch_taken  <= bus.in_valid && bus.is_branch && cond_true;
      bus.branch_target <= bus.target_in;
    end
  end

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed bench for alu_status_unit with an expected-value queue checked after each edge.
module tb_alu_status_unit;

  localparam logic [23:0] FULL       = 24'hFF_FFFF;
  localparam logic [23:0] FLUSH_MASK = 24'h80_4403;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [23:0] exp_q[$];

  alu_status_unit_if #(.WIDTH(8), .RADDR_W(3)) bus ();

  alu_status_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packing: {valid, result[8], wb_en, wb_reg[3], taken, target[8], z, c}
  function automatic logic [23:0] ev(logic v, logic [7:0] res, logic we, logic [2:0] wr,
                                     logic bt, logic [7:0] tgt, logic z, logic c);
    return {v, res, we, wr, bt, tgt, z, c};
  endfunction

  task automatic idle();
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.alu_result   = 8'h00;
    bus.alu_zero     = 1'b0;
    bus.alu_carry    = 1'b0;
    bus.upd_z        = 1'b0;
    bus.upd_c        = 1'b0;
    bus.wb_en_in     = 1'b0;
    bus.wb_reg_in    = 3'd0;
    bus.is_branch    = 1'b0;
    bus.cond         = 3'd0;
    bus.target_in    = 8'h00;
    bus.flag_save    = 1'b0;
    bus.flag_restore = 1'b0;
  endtask

  task automatic check_carry(input string tag, input logic exp_c);
    n_checks++;
    assert (bus.carry_to_alu === exp_c)
    else begin
      n_fail++;
      $error("FAIL %s carry_to_alu=%b exp=%b", tag, bus.carry_to_alu, exp_c);
    end
  endtask

  task automatic tick(input string tag, input logic [23:0] exp, input logic [23:0] mask);
    logic [23:0] obs;
    logic [23:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    obs = {bus.out_valid, bus.out_result, bus.out_wb_en, bus.out_wb_reg,
           bus.branch_taken, bus.branch_target, bus.z_flag, bus.c_flag};
    e = exp_q.pop_front();
    n_checks++;
    assert ((obs & mask) === (e & mask))
    else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    check_carry({tag, "_carry"}, e[0]);
  endtask

  initial begin
    logic [7:0] tk00;
    logic [7:0] tk11;
    tk00 = 8'b0101_0101;
    tk11 = 8'b0100_1011;

    idle();
    rst = 1'b1;
    tick("reset", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0), FULL);
    rst = 1'b0;

    // ADD 0xFF + 0x01
    bus.in_valid = 1'b1; bus.alu_result = 8'h00; bus.alu_zero = 1'b1; bus.alu_carry = 1'b1;
    bus.upd_z = 1'b1; bus.upd_c = 1'b1; bus.wb_en_in = 1'b1; bus.wb_reg_in = 3'd3;
    tick("add", ev(1, 8'h00, 1, 3'd3, 0, 8'h00, 1, 1), FULL);

    // ADC sees committed carry; only Z written
    bus.alu_result = 8'h42; bus.alu_zero = 1'b0; bus.alu_carry = 1'b0;
    bus.upd_c = 1'b0; bus.wb_reg_in = 3'd4;
    #1;
    check_carry("adc_pre", 1'b1);
    tick("adc", ev(1, 8'h42, 1, 3'd4, 0, 8'h00, 0, 1), FULL);

    // Branch C&!Z with Z=0,C=1
    idle();
    bus.in_valid = 1'b1; bus.is_branch = 1'b1; bus.cond = 3'b101;
    bus.target_in = 8'h3C; bus.alu_result = 8'h3C;
    tick("br_hi_taken", ev(1, 8'h3C, 0, 3'd0, 1, 8'h3C, 0, 1), FULL);

    bus.is_branch = 1'b0; bus.alu_result = 8'h00; bus.upd_z = 1'b1; bus.alu_zero = 1'b1;
    tick("set_z", ev(1, 8'h00, 0, 3'd0, 0, 8'h3C, 1, 1), FULL);

    bus.upd_z = 1'b0; bus.alu_zero = 1'b0; bus.is_branch = 1'b1; bus.alu_result = 8'h3C;
    tick("br_hi_not", ev(1, 8'h3C, 0, 3'd0, 0, 8'h3C, 1, 1), FULL);

    // Stall three cycles with a C-writing op waiting in EX
    bus.is_branch = 1'b0; bus.stall = 1'b1; bus.upd_c = 1'b1; bus.alu_carry = 1'b0;
    bus.alu_result = 8'h55; bus.wb_en_in = 1'b1; bus.wb_reg_in = 3'd5;
    for (int i = 0; i < 3; i++)
      tick("stall_hold", ev(1, 8'h3C, 0, 3'd0, 0, 8'h3C, 1, 1), FULL);
    bus.stall = 1'b0;
    tick("stall_release", ev(1, 8'h55, 1, 3'd5, 0, 8'h3C, 1, 0), FULL);

    // flush together with stall
    bus.stall = 1'b1; bus.flush = 1'b1; bus.upd_c = 1'b0; bus.upd_z = 1'b1;
    bus.alu_zero = 1'b0; bus.alu_result = 8'h77; bus.is_branch = 1'b1; bus.cond = 3'b000;
    tick("flush_stall", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 1, 0), FLUSH_MASK);

    // Save {1,0}, overwrite with {0,1}, restore against a concurrent C update
    idle();
    bus.flag_save = 1'b1;
    tick("save", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 1, 0), FULL);
    idle();
    bus.in_valid = 1'b1; bus.upd_z = 1'b1; bus.upd_c = 1'b1; bus.alu_zero = 1'b0;
    bus.alu_carry = 1'b1; bus.alu_result = 8'h80;
    tick("op_01", ev(1, 8'h80, 0, 3'd0, 0, 8'h00, 0, 1), FULL);
    bus.upd_z = 1'b0; bus.alu_result = 8'h81; bus.flag_restore = 1'b1;
    tick("restore_wins", ev(1, 8'h81, 0, 3'd0, 0, 8'h00, 1, 0), FULL);

    // Swap: flags 01, shadow 10
    bus.flag_restore = 1'b0; bus.upd_z = 1'b1; bus.alu_result = 8'h01;
    tick("op_01b", ev(1, 8'h01, 0, 3'd0, 0, 8'h00, 0, 1), FULL);
    idle();
    bus.flag_save = 1'b1; bus.flag_restore = 1'b1;
    tick("swap_flags", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 1, 0), FULL);
    bus.flag_save = 1'b0;
    tick("swap_shadow", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 1), FULL);

    // Reset while valid, taken and flags=11
    idle();
    bus.in_valid = 1'b1; bus.upd_z = 1'b1; bus.upd_c = 1'b1; bus.alu_zero = 1'b1;
    bus.alu_carry = 1'b1; bus.is_branch = 1'b1; bus.cond = 3'b000; bus.target_in = 8'h99;
    bus.alu_result = 8'h12; bus.wb_en_in = 1'b1; bus.wb_reg_in = 3'd7;
    tick("pre_reset", ev(1, 8'h12, 1, 3'd7, 1, 8'h99, 1, 1), FULL);
    rst = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1; bus.flag_save = 1'b1; bus.flag_restore = 1'b1;
    tick("mid_reset", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0), FULL);
    rst = 1'b0;
    idle();
    bus.flag_restore = 1'b1;
    tick("shadow_reset", ev(0, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0), FULL);

    // All condition codes with flags 00, then 11
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.is_branch = 1'b1; bus.cond = 3'(i); bus.target_in = 8'(i * 16);
      tick("cond_00", ev(1, 8'h00, 0, 3'd0, tk00[i], 8'(i * 16), 0, 0), FULL);
    end
    idle();
    bus.in_valid = 1'b1; bus.upd_z = 1'b1; bus.upd_c = 1'b1; bus.alu_zero = 1'b1; bus.alu_carry = 1'b1;
    tick("set_11", ev(1, 8'h00, 0, 3'd0, 0, 8'h00, 1, 1), FULL);
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.is_branch = 1'b1; bus.cond = 3'(i); bus.target_in = 8'(i + 1);
      tick("cond_11", ev(1, 8'h00, 0, 3'd0, tk11[i], 8'(i + 1), 1, 1), FULL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
